// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit:
// funct3 op encodings, FSM state type and default datapath width.
package ex_muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [2:0] md_mul    = 3'b000;
  localparam logic [2:0] md_mulh   = 3'b001;
  localparam logic [2:0] md_mulhsu = 3'b010;
  localparam logic [2:0] md_mulhu  = 3'b011;
  localparam logic [2:0] md_div    = 3'b100;
  localparam logic [2:0] md_divu   = 3'b101;
  localparam logic [2:0] md_rem    = 3'b110;
  localparam logic [2:0] md_remu   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_iter_step.sv
// One radix-2 iteration on the {hi, lo} working pair: right-shifting shift-add
// for multiply, left-shifting restoring subtract for divide.
module md_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    // Partial remainder stays below the divisor, so diff[XLEN] is a pure borrow flag.
    diff    = shifted - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = shifted[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: accepts one op via in_valid/in_ready, iterates
// BITS_PER_CYCLE bits per clock, and holds a registered writeback until out_ready.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN           = MD_XLEN,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      waddr_i,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wvalid_o,
  output logic [4:0]      waddr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            busy,
  output md_state_e       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and payload is held stable while valid && !ready.
  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]      wa_out_q, wa_out_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic [BITS_PER_CYCLE:0][XLEN-1:0] hi_c, lo_c;

  logic            in_fire, is_div, rs1_sgn, rs2_sgn, s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0] a1, a2, fast_res, quo, rem, mul_res, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign in_ready    = (state_q == MD_IDLE) && !flush;
  assign out_valid   = (state_q == MD_DONE);
  assign wvalid_o    = out_valid;
  assign busy        = (state_q != MD_IDLE);
  assign waddr_o     = wa_out_q;
  assign wdata_o     = wdata_q;
  assign dbg_state_o = state_q;
  assign in_fire     = in_valid && in_ready;

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    md_iter_step #(.XLEN(XLEN)) u_step (
      .is_div_i (op_q[2]),
      .hi_i     (hi_c[g]),
      .lo_i     (lo_c[g]),
      .opnd_i   (opnd_q),
      .hi_o     (hi_c[g+1]),
      .lo_o     (lo_c[g+1])
    );
  end

  // Accept-side decode: operand magnitudes, sign flags and the fast-path result.
  always_comb begin
    is_div   = op[2];
    rs1_sgn  = (op == md_mulh) || (op == md_mulhsu) || (op == md_div) || (op == md_rem);
    rs2_sgn  = (op == md_mulh) || (op == md_div) || (op == md_rem);
    s1       = rs1_sgn && rs1[XLEN-1];
    s2       = rs2_sgn && rs2[XLEN-1];
    a1       = s1 ? (~rs1 + 1'b1) : rs1;
    a2       = s2 ? (~rs2 + 1'b1) : rs2;
    div_zero = is_div && (rs2 == '0);
    div_ovf  = ((op == md_div) || (op == md_rem)) && (rs1 == MIN_NEG) && (rs2 == '1);
    if (op[1]) fast_res = div_zero ? rs1 : '0;
    else       fast_res = div_zero ? '1 : MIN_NEG;
  end

  // Completion-side fix-up, applied to the output of the final iteration.
  always_comb begin
    prod      = {hi_c[BITS_PER_CYCLE], lo_c[BITS_PER_CYCLE]};
    prod_s    = neg_q_q ? (~prod + 1'b1) : prod;
    mul_res   = (op_q == md_mul) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo       = neg_q_q ? (~lo_c[BITS_PER_CYCLE] + 1'b1) : lo_c[BITS_PER_CYCLE];
    rem       = neg_r_q ? (~hi_c[BITS_PER_CYCLE] + 1'b1) : hi_c[BITS_PER_CYCLE];
    final_res = !op_q[2] ? mul_res : (op_q[1] ? rem : quo);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    waddr_d  = waddr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    cnt_d    = cnt_q;
    wa_out_d = wa_out_q;
    wdata_d  = wdata_q;
    case (state_q)
      MD_IDLE: begin
        if (in_fire) begin
          op_d    = op;
          waddr_d = waddr_i;
          hi_d    = '0;
          lo_d    = a1;
          opnd_d  = a2;
          neg_q_d = s1 ^ s2;
          neg_r_d = s1;
          cnt_d   = CNT_W'(ITER - 1);
          if (div_zero || div_ovf) begin
            state_d  = MD_DONE;
            wa_out_d = waddr_i;
            wdata_d  = fast_res;
          end else begin
            state_d = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        hi_d  = hi_c[BITS_PER_CYCLE];
        lo_d  = lo_c[BITS_PER_CYCLE];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0 && !flush) begin
          state_d  = MD_DONE;
          wa_out_d = waddr_q;
          wdata_d  = final_res;
        end
      end
      MD_DONE: begin
        if (out_ready) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush && state_q != MD_IDLE) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      waddr_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      wa_out_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      waddr_q  <= waddr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      cnt_q    <= cnt_d;
      wa_out_q <= wa_out_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, backpressure, flush,
// async reset and randomised ops checked through an expected-result queue.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  waddr_i = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        wvalid_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        busy;
  md_state_e   dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  addr_q[$];

  ex_muldiv dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1(rs1), .rs2(rs2), .waddr_i(waddr_i), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .wvalid_o(wvalid_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] md_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    case (o)
      md_mul:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      md_mulh:   begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
      md_mulhsu: begin x = {{32{a[31]}}, a}; y = {32'b0, b}; p = x * y; return p[63:32]; end
      md_mulhu:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      md_div: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      md_divu: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      md_rem: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Presents one op, measures edges to out_valid (accept edge counted as 1),
  // stalls out_ready for 'stall' cycles, then consumes and scores the result.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] ad,
                       input logic [31:0] exp_d, input int exp_lat, input int stall);
    int edges;
    logic [31:0] e_d;
    logic [4:0]  e_a;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    op = o; rs1 = a; rs2 = b; waddr_i = ad; in_valid = 1'b1;
    exp_q.push_back(exp_d);
    addr_q.push_back(ad);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
      in_valid = 1'b0;
      op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; waddr_i = 5'($urandom);
      if (edges == 1 && exp_lat > 1)
        check({tag, "_state_busy"}, 32'(dbg_state), 32'(MD_BUSY));
    end while (!out_valid && edges < 100);
    e_d = exp_q.pop_front();
    e_a = addr_q.pop_front();
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_data"}, wdata_o, e_d);
      check({tag, "_stall_addr"}, 32'(waddr_o), 32'(e_a));
      check({tag, "_stall_rdy"}, 32'(in_ready), 32'd0);
      check({tag, "_stall_vld"}, 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    check({tag, "_data"}, wdata_o, e_d);
    check({tag, "_addr"}, 32'(waddr_o), 32'(e_a));
    check({tag, "_wvalid"}, 32'(wvalid_o), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int vcnt;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_wvalid", 32'(wvalid_o), 32'd0);
    check("rst_waddr", 32'(waddr_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op("mul",      md_mul,   32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 0);
    do_op("mulh",     md_mulh,  32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33, 0);
    do_op("mulhu",    md_mulhu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33, 0);
    do_op("mulhsu",   md_mulhsu,32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33, 0);
    do_op("divu_z",   md_divu,  32'd100,        32'd0,         5'd9,  32'hFFFF_FFFF, 1,  0);
    do_op("rem_z",    md_rem,   32'd100,        32'd0,         5'd10, 32'd100,       1,  0);
    do_op("div_ovf",  md_div,   32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1,  0);
    do_op("rem_ovf",  md_rem,   32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1,  0);
    do_op("div_neg",  md_div,   32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFD, 33, 5);
    do_op("rem_neg",  md_rem,   32'hFFFF_FFF9,  32'd2,         5'd14, 32'hFFFF_FFFF, 33, 0);
    do_op("remu",     md_remu,  32'd1000,       32'd7,         5'd15, 32'd6,         33, 2);

    // Flush 10 cycles into BUSY, with a competing op presented in the flush cycle.
    @(negedge clk);
    op = md_mul; rs1 = 32'd3; rs2 = 32'd4; waddr_i = 5'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; op = md_divu; rs1 = 32'd9; rs2 = 32'd3;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    vcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid || busy) vcnt++;
    end
    check("flush_no_result", 32'(vcnt), 32'd0);
    do_op("post_flush", md_mul, 32'd1234, 32'd5678, 5'd21, 32'd7006652, 33, 0);

    // Randomised ops checked against the reference model.
    for (int i = 0; i < 14; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_opnd();
      rb = pick_opnd();
      do_op("rand", ro, ra, rb, 5'($urandom), md_model(ro, ra, rb),
            (ro[2] && (rb == 0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 33,
            $urandom_range(0, 2));
    end

    // Asynchronous reset between edges while BUSY.
    @(negedge clk);
    op = md_div; rs1 = 32'd500; rs2 = 32'd7; waddr_i = 5'd30; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_wvalid", 32'(wvalid_o), 32'd0);
    check("arst_waddr", 32'(waddr_o), 32'd0);
    check("arst_wdata", wdata_o, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) vcnt++;
    end
    check("arst_no_result", 32'(vcnt), 32'd0);
    do_op("post_rst", md_divu, 32'd500, 32'd7, 5'd31, 32'd71, 33, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
